// File: rtl/packet_tx.sv
// packet_tx: serialises a five-byte packet (header + four data bytes), MSB first,
// with a fixed idle gap after every byte. Starts carrying a byte with bit 7 set
// are refused with a one-cycle reject pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; refuses starts whose data has a bit 7 set
// SHIFT | one bit of the current byte on serial_data, data_ena high
// GAP   | data_ena low for GAP_CYCLES cycles after each byte
// DONE  | one-cycle completion pulse, then back to IDLE
module packet_tx #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        start,
  input  logic        header_sel,
  input  logic [31:0] data_in,
  output logic        serial_data,
  output logic        data_ena,
  output logic        busy,
  output logic        done,
  output logic        reject
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);
  localparam logic [2:0] LAST_BYTE = 3'd4;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic [3:0]  gap_cnt;
  logic        hdr_q;
  logic [31:0] data_q;
  logic        reject_q;
  logic        start_bad;
  logic        accept;
  logic [7:0]  cur_byte;

  // Any data byte with its top bit set makes the whole request illegal.
  assign start_bad = data_in[31] | data_in[23] | data_in[15] | data_in[7];
  assign accept    = (state == IDLE) && start && !start_bad;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd0) state_nxt = GAP;
      GAP:     if (gap_cnt == 4'd0) state_nxt = (byte_idx == LAST_BYTE) ? DONE : SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, counters and the captured packet contents.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      byte_idx <= 3'd0;
      gap_cnt  <= 4'd0;
      hdr_q    <= 1'b0;
      data_q   <= 32'd0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      reject_q <= (state == IDLE) && start && start_bad;
      case (state)
        IDLE: begin
          if (accept) begin
            hdr_q    <= header_sel;
            data_q   <= data_in;
            bit_cnt  <= 3'd7;
            byte_idx <= 3'd0;
          end
        end
        SHIFT: begin
          // bit_cnt parks at 0 through the gap instead of wrapping.
          if (bit_cnt == 3'd0) gap_cnt <= GAP_LOAD;
          else                 bit_cnt <= bit_cnt - 3'd1;
        end
        GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else begin
            bit_cnt <= 3'd7;
            if (byte_idx != LAST_BYTE) byte_idx <= byte_idx + 3'd1;
          end
        end
        DONE: begin
          bit_cnt  <= 3'd0;
          byte_idx <= 3'd0;
        end
        default: ;
      endcase
    end
  end

  // Byte currently being shifted out: header first, then DATA_1..DATA_4.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      3'd0:    cur_byte = hdr_q ? 8'hC3 : 8'hA5;
      3'd1:    cur_byte = data_q[7:0];
      3'd2:    cur_byte = data_q[15:8];
      3'd3:    cur_byte = data_q[23:16];
      3'd4:    cur_byte = data_q[31:24];
      default: cur_byte = 8'h00;
    endcase
  end

  assign data_ena    = (state == SHIFT);
  assign serial_data = data_ena & cur_byte[bit_cnt];
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign reject      = reject_q;

endmodule

// File: tb/tb_packet_tx.sv
// Bench for packet_tx (GAP_CYCLES = 2): single-cycle vector table, full
// packets checked cycle by cycle, reset abort, and a byte-collecting receiver
// for back-to-back loopback.
module tb_packet_tx;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic        start;
  logic        header_sel;
  logic [31:0] data_in;
  logic        serial_data;
  logic        data_ena;
  logic        busy;
  logic        done;
  logic        reject;

  int n_checks = 0;
  int n_fail   = 0;

  packet_tx #(.GAP_CYCLES(2)) dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .start      (start),
    .header_sel (header_sel),
    .data_in    (data_in),
    .serial_data(serial_data),
    .data_ena   (data_ena),
    .busy       (busy),
    .done       (done),
    .reject     (reject)
  );

  // 50 MHz clock.
  always #10 clk_50 = ~clk_50;

  // Receiver: collects data bytes (header dropped) on the falling edge.
  logic [7:0] rx_sh = 8'h00;
  int         rx_bits = 0;
  int         rx_bytes = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk_50) begin
    if (reset_n === 1'b0) begin
      rx_bits  <= 0;
      rx_bytes <= 0;
    end else if (data_ena === 1'b1) begin
      rx_sh <= {rx_sh[6:0], serial_data};
      if (rx_bits == 7) begin
        rx_bits <= 0;
        if (rx_bytes != 0) rx_q.push_back({rx_sh[6:0], serial_data});
        rx_bytes <= (rx_bytes == 4) ? 0 : rx_bytes + 1;
      end else begin
        rx_bits <= rx_bits + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {serial_data, data_ena, busy, done, reject};
  endfunction

  // Sends one packet and checks every cycle against the nominal timeline:
  // byte j occupies cycles 10j+1..10j+8 after the accepting edge, done at 51.
  task automatic run_packet(input logic hsel, input logic [31:0] din,
                            input logic [39:0] exp_bytes, input bit disturb,
                            input string tag);
    int   pos, bi, dones;
    logic e_ena, e_ser;
    dones      = 0;
    header_sel = hsel;
    data_in    = din;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 51; t++) begin
      pos   = (t - 1) % 10;
      bi    = (t - 1) / 10;
      e_ena = (t <= 50) && (pos < 8);
      e_ser = 1'b0;
      if (e_ena) e_ser = exp_bytes[39 - 8*bi - pos];
      chk($sformatf("%s ena t%0d", tag, t), 32'(data_ena), 32'(e_ena));
      chk($sformatf("%s ser t%0d", tag, t), 32'(serial_data), 32'(e_ser));
      chk($sformatf("%s busy t%0d", tag, t), 32'(busy), 32'd1);
      chk($sformatf("%s reject t%0d", tag, t), 32'(reject), 32'd0);
      chk($sformatf("%s done t%0d", tag, t), 32'(done), 32'(t == 51));
      if (done === 1'b1) dones++;
      if (disturb && t == 5) begin
        data_in    = 32'hFFFF_FFFF;
        header_sel = ~hsel;
      end
      start = disturb && (t == 19);
      tick();
    end
    start = 1'b0;
    chk({tag, " done count"}, 32'(dones), 32'd1);
    chk({tag, " idle after"}, 32'(outs()), 32'd0);
  endtask

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        hsel;
    logic [31:0] din;
    logic [4:0]  exp;   // {serial_data, data_ena, busy, done, reject}
  } vec_t;

  vec_t vecs[12];

  initial begin
    int         base, dones;
    logic [31:0] lb_data[3];
    logic [7:0]  exp_b;

    reset_n    = 1'b0;
    start      = 1'b0;
    header_sel = 1'b0;
    data_in    = 32'd0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'b00000}; // reset state
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0102_8304, 5'b00001}; // bit 15 set -> reject
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0102_8304, 5'b00000}; // reject lasts one cycle
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 5'b00001}; // bit 31 set
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0080, 5'b00001}; // bit 7 set
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b00000};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 5'b00000}; // reset beats start
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b00000};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 5'b11100}; // accept: A5 bit7 next cycle
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b01100}; // A5 bit6 = 0
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'b00000}; // reset mid-header
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'b00000};

    for (int i = 0; i < 12; i++) begin
      reset_n    = vecs[i].rst_n;
      start      = vecs[i].start;
      header_sel = vecs[i].hsel;
      data_in    = vecs[i].din;
      tick();
      chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(vecs[i].exp));
    end
    start = 1'b0;
    tick();

    // Basic packet and C3 header with edge data.
    run_packet(1'b0, 32'h0403_0201, 40'hA5_01_02_03_04, 1'b0, "basic");
    run_packet(1'b1, 32'h7F00_7F00, 40'hC3_00_7F_00_7F, 1'b0, "c3");
    // Input changes and a start while busy must not disturb the packet.
    run_packet(1'b0, 32'h0403_0201, 40'hA5_01_02_03_04, 1'b1, "busy_start");

    // Reset at cycle k+15: everything quiet next cycle, no done, no resume.
    header_sel = 1'b0;
    data_in    = 32'h0403_0201;
    start      = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    reset_n = 1'b0;
    tick();
    chk("rst mid outs", 32'(outs()), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      tick();
    end
    chk("rst no resume", 32'(dones), 32'd0);
    run_packet(1'b0, 32'h0403_0201, 40'hA5_01_02_03_04, 1'b0, "after_rst");

    // Loopback: three packets, each start raised as soon as busy falls.
    lb_data[0] = 32'h4433_2211;
    lb_data[1] = 32'h7E5A_3C01;
    lb_data[2] = 32'h0F1E_2D3C;
    base = rx_q.size();
    for (int p = 0; p < 3; p++)
      run_packet(1'b0, lb_data[p],
                 {8'hA5, lb_data[p][7:0], lb_data[p][15:8], lb_data[p][23:16], lb_data[p][31:24]},
                 1'b0, $sformatf("loop%0d", p));
    tick();
    chk("loop byte count", 32'(rx_q.size() - base), 32'd12);
    for (int i = 0; i < 12; i++) begin
      exp_b = lb_data[i/4][8*(i%4) +: 8];
      if (base + i < rx_q.size())
        chk($sformatf("loop byte%0d", i), 32'(rx_q[base + i]), 32'(exp_b));
      else
        chk($sformatf("loop byte%0d missing", i), 32'hFFFF_FFFF, 32'(exp_b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
